// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, loader state encoding and slot-index helper
// for the convolution window loader.
package cnn_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 256;
  localparam int MAX_K  = 5;
  localparam int K3     = 3;
  localparam int K5     = 5;
  localparam int NSLOT  = MAX_K * MAX_K;
  localparam int SLOT_W = $clog2(NSLOT);
  localparam int RC_W   = $clog2(MAX_K + 1);

  typedef logic [RC_W-1:0]   rc_t;
  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD
  } loader_state_e;

  // Flat window slot for row r, column c (row pitch MAX_K).
  function automatic slot_t slot_idx(input rc_t r, input rc_t c);
    return SLOT_W'(r) * SLOT_W'(MAX_K) + SLOT_W'(c);
  endfunction

endpackage

// File: rtl/window_loader_if.sv
// window_loader_if: address-generator, image-memory and MAC-array side
// signals of the window loader. slave = loader, master = its environment.
interface window_loader_if;
  import cnn_pkg::*;

  logic                    FILTER;
  logic                    START;
  logic [ADDR_W-1:0]       BASE_ADRS;
  logic                    BUSY;
  logic [ADDR_W-1:0]       MEM_ADRS;
  logic                    MEM_RD;
  logic [DATA_W-1:0]       MEM_DATA;
  logic [NSLOT*DATA_W-1:0] WIN_DATA;
  logic                    WIN_VALID;
  logic                    WIN_ACK;

  modport slave (
    input  FILTER, START, BASE_ADRS, MEM_DATA, WIN_ACK,
    output BUSY, MEM_ADRS, MEM_RD, WIN_DATA, WIN_VALID
  );

  modport master (
    output FILTER, START, BASE_ADRS, MEM_DATA, WIN_ACK,
    input  BUSY, MEM_ADRS, MEM_RD, WIN_DATA, WIN_VALID
  );

endinterface

// File: rtl/loader_addr_gen.sv
// loader_addr_gen: row/col walk over a KxK window. The read address is the
// row base plus column, with the row base stepped by IMG_W at each row wrap,
// so no multiplier is needed. All arithmetic wraps modulo 2^ADDR_W.
module loader_addr_gen
  import cnn_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              big,
  input  logic              step,
  output logic [ADDR_W-1:0] adrs,
  output logic              last_rd,
  output slot_t             slot
);

  rc_t               r_q, r_d, c_q, c_d, k_q, k_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  rc_t               k_last;

  assign k_last = rc_t'(k_q - rc_t'(1));

  // Counter update: restart on load, advance one pixel per fetch cycle.
  always_comb begin
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    if (load) begin
      r_d        = '0;
      c_d        = '0;
      k_d        = big ? rc_t'(K5) : rc_t'(K3);
      row_base_d = base;
    end else if (step) begin
      if (c_q == k_last) begin
        c_d        = '0;
        r_d        = rc_t'(r_q + rc_t'(1));
        row_base_d = row_base_q + ADDR_W'(IMG_W);
      end else begin
        c_d = rc_t'(c_q + rc_t'(1));
      end
    end
  end

  // Counter and row-base registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= rc_t'(K3);
      row_base_q <= '0;
    end else begin
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
    end
  end

  // Address adder, last-pixel flag and slot index of the current read.
  always_comb begin
    adrs    = row_base_q + ADDR_W'(c_q);
    last_rd = (r_q == k_last) && (c_q == k_last);
    slot    = slot_idx(r_q, c_q);
  end

endmodule

// File: rtl/window_loader.sv
// window_loader: accepts a window base address while idle, bursts single-pixel
// reads over a 3x3 or 5x5 window and holds the assembled window for the MAC
// array until acknowledged.
// Optional feature: define LOADER_CNT_EN to add the WIN_CNT delivered-window
// counter port.
module window_loader
  import cnn_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  window_loader_if.slave bus
`ifdef LOADER_CNT_EN
  ,
  output logic [15:0]    WIN_CNT
`endif
);

  loader_state_e     state_q, state_d;
  logic              load, step, mem_rd, last_rd;
  slot_t             slot;
  logic              rd_vld_p1_q, rd_vld_p1_d;
  slot_t             slot_p1_q, slot_p1_d;
  logic [DATA_W-1:0] win_q [NSLOT];
  logic [DATA_W-1:0] win_d [NSLOT];

  loader_addr_gen u_addr_gen (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .base    (bus.BASE_ADRS),
    .big     (bus.FILTER),
    .step    (step),
    .adrs    (bus.MEM_ADRS),
    .last_rd (last_rd),
    .slot    (slot)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; START outside IDLE is simply never looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.START)   state_d = ST_FETCH;
      ST_FETCH: if (last_rd)     state_d = ST_DRAIN;
      ST_DRAIN:                  state_d = ST_HOLD;
      ST_HOLD:  if (bus.WIN_ACK) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    load          = 1'b0;
    step          = 1'b0;
    mem_rd        = 1'b0;
    bus.BUSY      = 1'b1;
    bus.WIN_VALID = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.BUSY = 1'b0;
        load     = bus.START;
      end
      ST_FETCH: begin
        step   = 1'b1;
        mem_rd = 1'b1;
      end
      ST_HOLD:  bus.WIN_VALID = 1'b1;
      default: ;
    endcase
  end

  assign bus.MEM_RD = mem_rd;

  // Read pipeline: slot and strobe delayed to line up with MEM_DATA.
  always_comb begin
    rd_vld_p1_d = mem_rd;
    slot_p1_d   = slot;
  end

  // Stage p1 strobe; reset discards a read still in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_vld_p1_q <= 1'b0;
    else     rd_vld_p1_q <= rd_vld_p1_d;
  end

  // Stage p1 slot index, qualified by rd_vld_p1_q.
  always_ff @(posedge CLK) begin
    slot_p1_q <= slot_p1_d;
  end

  // Window file: cleared on a new window, one slot written per returned pixel.
  always_comb begin
    win_d = win_q;
    if (load) begin
      for (int i = 0; i < NSLOT; i++) win_d[i] = '0;
    end else if (rd_vld_p1_q) begin
      win_d[slot_p1_q] = bus.MEM_DATA;
    end
  end

  // Window file registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NSLOT; i++) win_q[i] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  // Flatten the window file onto WIN_DATA.
  always_comb begin
    bus.WIN_DATA = '0;
    for (int i = 0; i < NSLOT; i++) bus.WIN_DATA[i*DATA_W +: DATA_W] = win_q[i];
  end

`ifdef LOADER_CNT_EN
  logic [15:0] win_cnt_q, win_cnt_d;

  // Delivered-window count, bumped on each HOLD-to-IDLE handoff; wraps.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (state_q == ST_HOLD && bus.WIN_ACK) win_cnt_d = win_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) win_cnt_q <= '0;
    else     win_cnt_q <= win_cnt_d;
  end

  assign WIN_CNT = win_cnt_q;
`endif

endmodule

// File: tb/tb_window_loader.sv
// tb_window_loader: scoreboard bench for window_loader. Expected addresses and
// window contents are computed from the launched base/filter; the memory model
// returns pix(address) one cycle after each read.
module tb_window_loader;
  import cnn_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  window_loader_if bus ();
`ifdef LOADER_CNT_EN
  logic [15:0] win_cnt;
`endif

  window_loader dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef LOADER_CNT_EN
    ,
    .WIN_CNT (win_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [ADDR_W-1:0]       exp_adrs[$];
  logic [ADDR_W-1:0]       obs_adrs[$];
  logic [NSLOT*DATA_W-1:0] exp_win;

  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'hA5;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Image memory: data one cycle after the read strobe, garbage otherwise.
  always @(posedge CLK) bus.MEM_DATA <= bus.MEM_RD ? pix(bus.MEM_ADRS) : 8'($urandom);

  // Drive a START for one window and push its expected reads/contents.
  task automatic launch(input logic f, input logic [ADDR_W-1:0] base);
    int k;
    logic [ADDR_W-1:0] a;
    k = f ? 5 : 3;
    exp_adrs.delete();
    exp_win = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++) begin
        a = base + ADDR_W'(r * IMG_W + c);
        exp_adrs.push_back(a);
        exp_win[(r*MAX_K+c)*DATA_W +: DATA_W] = pix(a);
      end
    bus.FILTER    = f;
    bus.BASE_ADRS = base;
    bus.START     = 1'b1;
  endtask

  // Step cycles after a launch, recording read addresses until WIN_VALID.
  // vc is the cycle (START cycle = 0) where WIN_VALID is first seen, -1 if never.
  task automatic collect(input int glitch_at, output int vc);
    vc = -1;
    obs_adrs.delete();
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        bus.START  = 1'b0;
        bus.FILTER = ~bus.FILTER;
      end
      if (n == glitch_at) begin
        bus.START     = 1'b1;
        bus.BASE_ADRS = 17'h05555;
        bus.FILTER    = ~bus.FILTER;
      end
      if (n == glitch_at + 1) bus.START = 1'b0;
      if (bus.MEM_RD) obs_adrs.push_back(bus.MEM_ADRS);
      if (bus.WIN_VALID) begin
        vc = n;
        break;
      end
    end
  endtask

  task automatic ack_now();
    bus.WIN_ACK = 1'b1;
    @(negedge CLK);
    bus.WIN_ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.START = 1'b0; bus.FILTER = 1'b0; bus.BASE_ADRS = '0; bus.WIN_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.BUSY); end
    total++; if (bus.MEM_RD !== 1'b0) begin bad++; $display("FAIL rst_memrd got=%b want=0", bus.MEM_RD); end
    total++; if (bus.MEM_ADRS !== '0) begin bad++; $display("FAIL rst_adrs got=%05h want=0", bus.MEM_ADRS); end
    total++; if (bus.WIN_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.WIN_VALID); end
    total++; if (bus.WIN_DATA !== '0) begin bad++; $display("FAIL rst_win got=%h want=0", bus.WIN_DATA); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_3x3();
    int vc;
    logic [ADDR_W-1:0] e, o;
    launch(1'b0, 17'h00100);
    collect(0, vc);
    total++; if (obs_adrs.size() != exp_adrs.size()) begin bad++; $display("FAIL k3_nreads got=%0d want=%0d", obs_adrs.size(), exp_adrs.size()); end
    while (exp_adrs.size() > 0 && obs_adrs.size() > 0) begin
      e = exp_adrs.pop_front(); o = obs_adrs.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL k3_adrs got=%05h want=%05h", o, e); end
    end
    total++; if (vc != 11) begin bad++; $display("FAIL k3_valid_cycle got=%0d want=11", vc); end
    total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL k3_win got=%h want=%h", bus.WIN_DATA, exp_win); end
    ack_now();
    total++; if (bus.WIN_VALID !== 1'b0) begin bad++; $display("FAIL k3_valid_drop got=%b want=0", bus.WIN_VALID); end
  endtask

  task automatic test_5x5_wrap();
    int vc;
    logic [ADDR_W-1:0] e, o;
    launch(1'b1, 17'h1FFFE);
    collect(0, vc);
    total++; if (obs_adrs.size() != 25) begin bad++; $display("FAIL k5_nreads got=%0d want=25", obs_adrs.size()); end
    while (exp_adrs.size() > 0 && obs_adrs.size() > 0) begin
      e = exp_adrs.pop_front(); o = obs_adrs.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL k5_adrs got=%05h want=%05h", o, e); end
    end
    total++; if (vc != 27) begin bad++; $display("FAIL k5_valid_cycle got=%0d want=27", vc); end
    total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL k5_win got=%h want=%h", bus.WIN_DATA, exp_win); end
    ack_now();
  endtask

  task automatic test_start_ignored();
    int vc;
    logic [ADDR_W-1:0] e, o;
    launch(1'b0, 17'h03000);
    collect(4, vc);
    total++; if (obs_adrs.size() != exp_adrs.size()) begin bad++; $display("FAIL ign_nreads got=%0d want=%0d", obs_adrs.size(), exp_adrs.size()); end
    while (exp_adrs.size() > 0 && obs_adrs.size() > 0) begin
      e = exp_adrs.pop_front(); o = obs_adrs.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL ign_adrs got=%05h want=%05h", o, e); end
    end
    total++; if (vc != 11) begin bad++; $display("FAIL ign_valid_cycle got=%0d want=11", vc); end
    total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL ign_win got=%h want=%h", bus.WIN_DATA, exp_win); end
    ack_now();
  endtask

  task automatic test_hold_back_to_back();
    int vc, c2, c3;
    launch(1'b0, 17'h00A10);
    collect(0, vc);
    total++; if (vc != 11) begin bad++; $display("FAIL hold_valid_cycle got=%0d want=11", vc); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      total++; if (bus.WIN_VALID !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b want=1", bus.WIN_VALID); end
      total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL hold_win got=%h want=%h", bus.WIN_DATA, exp_win); end
    end
    ack_now();
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL hold_idle_busy got=%b want=0", bus.BUSY); end
    total++; if (bus.WIN_VALID !== 1'b0) begin bad++; $display("FAIL hold_valid_drop got=%b want=0", bus.WIN_VALID); end
    launch(1'b0, 17'h00B20);
    c2 = cyc;
    collect(0, vc);
    total++; if (vc != 11) begin bad++; $display("FAIL b2b_valid_cycle1 got=%0d want=11", vc); end
    total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL b2b_win1 got=%h want=%h", bus.WIN_DATA, exp_win); end
    ack_now();
    launch(1'b0, 17'h0C0C0);
    c3 = cyc;
    total++; if (c3 - c2 != 12) begin bad++; $display("FAIL b2b_period got=%0d want=12", c3 - c2); end
    collect(0, vc);
    total++; if (vc != 11) begin bad++; $display("FAIL b2b_valid_cycle2 got=%0d want=11", vc); end
    total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL b2b_win2 got=%h want=%h", bus.WIN_DATA, exp_win); end
    // Ack and START together in HOLD: START must be dropped.
    bus.START = 1'b1; bus.BASE_ADRS = 17'h01234;
    ack_now();
    bus.START = 1'b0;
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL ack_start_busy got=%b want=0", bus.BUSY); end
    @(negedge CLK);
    total++; if (bus.MEM_RD !== 1'b0) begin bad++; $display("FAIL ack_start_memrd got=%b want=0", bus.MEM_RD); end
  endtask

  task automatic test_reset_mid_burst();
    int vc;
    logic [ADDR_W-1:0] e, o;
    launch(1'b1, 17'h01000);
    for (int n = 1; n <= 4; n++) begin
      @(negedge CLK);
      if (n == 1) bus.START = 1'b0;
    end
    total++; if (bus.MEM_RD !== 1'b1) begin bad++; $display("FAIL mid_memrd_before got=%b want=1", bus.MEM_RD); end
    RST = 1'b1;
    #1;
    total++; if (bus.MEM_RD !== 1'b0) begin bad++; $display("FAIL mid_memrd got=%b want=0", bus.MEM_RD); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.BUSY); end
    total++; if (bus.MEM_ADRS !== '0) begin bad++; $display("FAIL mid_adrs got=%05h want=0", bus.MEM_ADRS); end
    total++; if (bus.WIN_DATA !== '0) begin bad++; $display("FAIL mid_win got=%h want=0", bus.WIN_DATA); end
    @(negedge CLK);
    total++; if (bus.WIN_DATA !== '0) begin bad++; $display("FAIL mid_win_late got=%h want=0", bus.WIN_DATA); end
    RST = 1'b0;
    @(negedge CLK);
    launch(1'b0, 17'h02204);
    collect(0, vc);
    total++; if (obs_adrs.size() != 9) begin bad++; $display("FAIL post_nreads got=%0d want=9", obs_adrs.size()); end
    while (exp_adrs.size() > 0 && obs_adrs.size() > 0) begin
      e = exp_adrs.pop_front(); o = obs_adrs.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL post_adrs got=%05h want=%05h", o, e); end
    end
    total++; if (vc != 11) begin bad++; $display("FAIL post_valid_cycle got=%0d want=11", vc); end
    total++; if (bus.WIN_DATA !== exp_win) begin bad++; $display("FAIL post_win got=%h want=%h", bus.WIN_DATA, exp_win); end
    ack_now();
  endtask

`ifdef LOADER_CNT_EN
  task automatic test_count();
    int vc;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++; if (win_cnt !== 16'd0) begin bad++; $display("FAIL cnt_reset got=%0d want=0", win_cnt); end
    for (int i = 0; i < 3; i++) begin
      launch(1'b0, 17'h00400 + ADDR_W'(i));
      collect(0, vc);
      ack_now();
    end
    total++; if (win_cnt !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d want=3", win_cnt); end
    dut.win_cnt_q = 16'hFFFF;
    launch(1'b1, 17'h00800);
    collect(0, vc);
    ack_now();
    total++; if (win_cnt !== 16'd0) begin bad++; $display("FAIL cnt_wrap got=%0d want=0", win_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_3x3();
    test_5x5_wrap();
    test_start_ignored();
    test_hold_back_to_back();
    test_reset_mid_burst();
`ifdef LOADER_CNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_loader.md
# window_loader

Fetch stage directly downstream of the convolution address generator: accepts each window base address it produces, issues a burst of single-byte reads to the image memory covering a 3x3 or 5x5 pixel window, and assembles the returned pixels into a flat window register. The assembled window is presented to the MAC array with a valid/ack handshake; a new base address is accepted only when the loader is idle.

## Interface
- ADDR_W, 17, image-memory address width (matches generator ADRS width)
- DATA_W, 8, pixel width
- IMG_W, 256, row pitch in pixels; power of two, ≤ 2^ADDR_W
- MAX_K, 5, largest supported window edge

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- FILTER  in  1  window size select: 0 = 3x3, 1 = 5x5; sampled with START
- START  in  1  base address valid from the address generator
- BASE_ADRS  in  ADDR_W  top-left pixel address of the window
- BUSY  out  1  high in any state other than IDLE; START is ignored while high
- MEM_ADRS  out  ADDR_W  read address to image memory
- MEM_RD  out  1  read strobe, one pixel per cycle
- MEM_DATA  in  DATA_W  read data, valid exactly 1 cycle after MEM_RD
- WIN_DATA  out  MAX_K*MAX_K*DATA_W  window pixels, slot r*MAX_K+c at bits [(r*MAX_K+c)*DATA_W +: DATA_W]
- WIN_VALID  out  1  window complete and stable
- WIN_ACK  in  1  consumer has taken the window
- WIN_CNT  out  16  windows delivered (only with LOADER_CNT_EN)

## Operation
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE: on START, latch BASE_ADRS, latch K = FILTER ? 5 : 3, clear row/col counters and all WIN_DATA slots, go to FETCH.
- FETCH: each cycle drive MEM_RD=1, MEM_ADRS = base + r*IMG_W + c, computed incrementally: a row-base register is advanced by IMG_W at row wrap and col is added to it. col runs 0..K-1, then wraps to 0 with r+1. After issuing (K-1,K-1), go to DRAIN.
- Read pipeline: a registered copy of the slot index (r,c) and a registered MEM_RD qualify the write of MEM_DATA into slot r*MAX_K+c on the following cycle.
- DRAIN: one cycle; the last returned pixel is written; go to HOLD.
- HOLD: WIN_VALID=1, WIN_DATA frozen. On WIN_ACK go to IDLE; WIN_VALID drops the next cycle.
- 3x3 windows use slots with r,c < 3; all other slots read 0.
- Address arithmetic is modulo 2^ADDR_W: a window crossing the top of memory wraps to low addresses silently. No row-edge clipping; the generator guarantees legal windows.
- START in any state other than IDLE is dropped, not queued. START and WIN_ACK in the same HOLD cycle: the ack is taken and the START is dropped.
- FILTER changes after the START cycle have no effect on the window in progress.

## Timing
- Reset values: BUSY=0, MEM_RD=0, MEM_ADRS=0, WIN_VALID=0, WIN_DATA all 0, WIN_CNT=0, state IDLE.
- START in cycle 0 gives the first MEM_RD in cycle 1 and the last MEM_RD in cycle K*K. DRAIN runs in cycle K*K+1 and WIN_VALID rises in cycle K*K+2: cycle 11 for 3x3, cycle 27 for 5x5.
- Shortest back-to-back spacing: if WIN_ACK arrives in the first HOLD cycle, the loader is in IDLE the next cycle and can accept START there. That gives K*K+3 cycles per window.
- RST asserted mid-burst: MEM_RD drops and outputs return to reset values asynchronously. Any read data arriving on the next cycle is discarded.

## Configuration
- LOADER_CNT_EN defined: WIN_CNT increments on each HOLD-to-IDLE transition and wraps 0xFFFF to 0.
- LOADER_CNT_EN undefined: the WIN_CNT port and counter are absent.

## Structure
- The shared package cnn_pkg holds:
  - ADDR_W, DATA_W, IMG_W, K3=3, K5=5
  - the loader state enum
  - a slot-index function
- Sub-module loader_addr_gen contains the row/col counters, the row-base register and the MEM_ADRS adder. It exposes last-read and slot-index outputs.
- window_loader holds the FSM, the read pipeline registers and the window register file.

## Test plan
- Reset then 3x3, FILTER=0, BASE_ADRS=0x00100:
  - MEM_ADRS sequence 0x00100,101,102,200,201,202,300,301,302.
  - WIN_VALID rises in cycle 11.
  - Slots 0..2, 5..7 and 10..12 hold the returned data; all other slots are 0.
- 5x5, FILTER=1, BASE_ADRS=0x1FFFE: addresses wrap, giving 0x1FFFE,0x1FFFF,0x00000,0x00001,0x00002, then 0x000FE onward; 25 reads; WIN_VALID rises in cycle 27.
- START pulsed during FETCH with a different base: ignored; the address sequence and data of the current window are unchanged.
- WIN_ACK held low for 10 HOLD cycles: WIN_DATA stable and WIN_VALID stays high. After the ack, a START the next cycle is accepted, giving a 12-cycle period for 3x3.
- RST asserted at the 4th read of a 5x5 burst: all outputs 0 immediately. A fresh 3x3 START afterwards completes correctly, with no stale data in slots 3,4 or rows 3,4.
- With LOADER_CNT_EN defined: after 3 acknowledged windows WIN_CNT=3. Forcing the counter to 0xFFFF and completing one more window gives 0.
